// File: rtl/rgb_ctrl_pkg.sv
// Shared encodings for the RGB delay configuration controller:
// send/config state types, requester index map and default widths.
package rgb_ctrl_pkg;

  localparam int unsigned TAP_W_DEF   = 5;
  localparam int unsigned MAX_TAP_DEF = 31;

  // Requester index map; the index is also the delay-line tap address
  typedef enum logic [3:0] {
    R_WHOLE = 4'd0,
    G_WHOLE = 4'd1,
    B_WHOLE = 4'd2,
    R_RISE  = 4'd3,
    G_RISE  = 4'd4,
    B_RISE  = 4'd5,
    R_FALL  = 4'd6,
    G_FALL  = 4'd7,
    B_FALL  = 4'd8
  } req_idx_t;

  localparam int unsigned N_REQ_DEF = int'(B_FALL) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SENDING,
    S_DRAIN
  } send_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_WRITE
  } cfg_state_t;

endpackage

// File: rtl/rgb_delay_cfg_ctrl_edge_rise.sv
// Single-bit rising-edge detector: rise is high for the one cycle in which
// din is high and its registered copy is still low.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/rgb_delay_cfg_ctrl.sv
// Control-plane sequencer for the PAM4 RGB transmitter: send-enable FSM plus
// frame-aligned, fixed-priority tap-update writes to the delay lines.
module rgb_delay_cfg_ctrl
  import rgb_ctrl_pkg::*;
#(
  parameter int unsigned TAP_W   = TAP_W_DEF,
  parameter int unsigned MAX_TAP = MAX_TAP_DEF,
  parameter int unsigned N_REQ   = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] btn_req,
  input  logic             send_enable_button,
  input  logic             send_stop_button,
  input  logic             frame_boundary,
  input  logic             cfg_ready,
  output logic             cfg_valid,
  output logic [3:0]       cfg_addr,
  output logic [TAP_W-1:0] cfg_data,
  output logic             send_en,
  output logic [3:0]       led_state
);

  logic [N_REQ-1:0] req_rise;
  logic             en_rise;
  logic             stop_rise;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_edge
    edge_rise u_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_req[gi]),
      .rise (req_rise[gi])
    );
  end

  edge_rise u_en_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (send_enable_button),
    .rise (en_rise)
  );

  edge_rise u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (send_stop_button),
    .rise (stop_rise)
  );

  send_state_t      send_st;
  send_state_t      send_nxt;
  cfg_state_t       cfg_st;
  cfg_state_t       cfg_nxt;
  logic [N_REQ-1:0] pending;
  logic             rearm;
  logic [TAP_W-1:0] tap [N_REQ];
  logic [3:0]       nxt_grant;
  logic             any_pend;
  logic             found;
  logic             accept;

  function automatic logic [TAP_W-1:0] tap_inc(input logic [TAP_W-1:0] t);
    return (t == TAP_W'(MAX_TAP)) ? '0 : t + TAP_W'(1);
  endfunction

  // Fixed priority: lowest pending index wins
  always_comb begin
    nxt_grant = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pending[i] && !found) begin
        nxt_grant = 4'(i);
        found     = 1'b1;
      end
    end
    any_pend = |pending;
  end

  always_comb begin
    send_nxt = send_st;
    case (send_st)
      S_IDLE:    if (en_rise && !stop_rise) send_nxt = S_SENDING;
      S_SENDING: if (stop_rise)             send_nxt = S_DRAIN;
      S_DRAIN:   if (frame_boundary)        send_nxt = S_IDLE;
      default:                              send_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_nxt = cfg_st;
    case (cfg_st)
      C_IDLE:  if (any_pend) cfg_nxt = (send_st == S_IDLE) ? C_WRITE : C_WAIT;
      C_WAIT:  if (frame_boundary || send_st == S_IDLE) cfg_nxt = C_WRITE;
      C_WRITE: if (cfg_ready) cfg_nxt = C_IDLE;
      default: cfg_nxt = C_IDLE;
    endcase
  end

  assign accept = (cfg_st == C_WRITE) && cfg_ready;

  // cfg_addr doubles as the grant register; it and cfg_data only load on a
  // new grant so they stay stable for the whole handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_st   <= S_IDLE;
      cfg_st    <= C_IDLE;
      send_en   <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      led_state <= 4'b0001;
      pending   <= '0;
      rearm     <= 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) tap[i] <= '0;
    end else begin
      send_st   <= send_nxt;
      cfg_st    <= cfg_nxt;
      send_en   <= (send_nxt != S_IDLE);
      cfg_valid <= (cfg_nxt == C_WRITE);
      led_state <= {cfg_nxt != C_IDLE, send_nxt == S_DRAIN,
                    send_nxt == S_SENDING, send_nxt == S_IDLE};

      if (cfg_st == C_IDLE && any_pend) begin
        cfg_addr <= nxt_grant;
        cfg_data <= tap_inc(tap[nxt_grant]);
      end

      pending <= pending | req_rise;
      if (accept) begin
        tap[cfg_addr]     <= cfg_data;
        // An edge seen mid-write re-arms the request instead of being absorbed
        pending[cfg_addr] <= rearm | req_rise[cfg_addr];
        rearm             <= 1'b0;
      end else if (cfg_st == C_WRITE && req_rise[cfg_addr]) begin
        rearm <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_delay_cfg_ctrl.sv
// Self-checking bench for rgb_delay_cfg_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural reference model.
module tb_rgb_delay_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] btn_req;
  logic       send_enable_button;
  logic       send_stop_button;
  logic       frame_boundary;
  logic       cfg_ready;
  logic       cfg_valid;
  logic [3:0] cfg_addr;
  logic [4:0] cfg_data;
  logic       send_en;
  logic [3:0] led_state;

  rgb_delay_cfg_ctrl #(.TAP_W(5), .MAX_TAP(31), .N_REQ(9)) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_req            (btn_req),
    .send_enable_button (send_enable_button),
    .send_stop_button   (send_stop_button),
    .frame_boundary     (frame_boundary),
    .cfg_ready          (cfg_ready),
    .cfg_valid          (cfg_valid),
    .cfg_addr           (cfg_addr),
    .cfg_data           (cfg_data),
    .send_en            (send_en),
    .led_state          (led_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0/1/2 = idle/sending/draining; phase 0/1/2 =
  // no write / waiting for frame / offering write.
  int         m_mode, m_phase, m_grant, m_data;
  int         m_tap [9];
  logic [8:0] m_pend, m_prev;
  logic       m_prev_en, m_prev_stop, m_again;

  function automatic int lowest(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_update();
    logic [8:0] edges, next_pend;
    logic       en_e, stop_e;
    int         old_mode, old_phase;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_grant = 0; m_data = 0;
      m_pend = '0; m_prev = '0; m_prev_en = 1'b0; m_prev_stop = 1'b0;
      m_again = 1'b0;
      for (int i = 0; i < 9; i++) m_tap[i] = 0;
      return;
    end
    edges  = btn_req & ~m_prev;
    en_e   = send_enable_button & ~m_prev_en;
    stop_e = send_stop_button & ~m_prev_stop;
    old_mode  = m_mode;
    old_phase = m_phase;
    next_pend = m_pend | edges;

    if (old_mode == 0 && en_e && !stop_e) m_mode = 1;
    else if (old_mode == 1 && stop_e)     m_mode = 2;
    else if (old_mode == 2 && frame_boundary) m_mode = 0;

    if (old_phase == 0 && m_pend != 0) begin
      m_grant = lowest(m_pend);
      m_data  = (m_tap[m_grant] + 1) % 32;
      m_phase = (old_mode == 0) ? 2 : 1;
    end else if (old_phase == 1 && (frame_boundary || old_mode == 0)) begin
      m_phase = 2;
    end else if (old_phase == 2) begin
      if (cfg_ready) begin
        m_tap[m_grant]    = m_data;
        next_pend[m_grant] = m_again | edges[m_grant];
        m_again = 1'b0;
        m_phase = 0;
      end else if (edges[m_grant]) begin
        m_again = 1'b1;
      end
    end
    m_pend      = next_pend;
    m_prev      = btn_req;
    m_prev_en   = send_enable_button;
    m_prev_stop = send_stop_button;
  endtask

  task automatic step();
    int exp_led;
    @(posedge clk);
    model_update();
    #1;
    exp_led = (m_phase != 0 ? 8 : 0) + (m_mode == 2 ? 4 : 0) +
              (m_mode == 1 ? 2 : 0) + (m_mode == 0 ? 1 : 0);
    check("m_valid", int'(cfg_valid), (m_phase == 2) ? 1 : 0);
    check("m_addr",  int'(cfg_addr),  m_grant);
    check("m_data",  int'(cfg_data),  m_data);
    check("m_send",  int'(send_en),   (m_mode != 0) ? 1 : 0);
    check("m_led",   int'(led_state), exp_led);
  endtask

  task automatic press(input int idx);
    btn_req[idx] = 1'b1;
    step();
    btn_req[idx] = 1'b0;
  endtask

  task automatic wait_accept(output int addr, output int data);
    addr = -1;
    data = -1;
    for (int i = 0; i < 20; i++) begin
      if (cfg_valid && cfg_ready) begin
        addr = int'(cfg_addr);
        data = int'(cfg_data);
        step();
        return;
      end
      step();
    end
    check("accept_timeout", 0, 1);
  endtask

  initial begin
    int a, d;
    rst = 1'b1; btn_req = '0; send_enable_button = 1'b0; send_stop_button = 1'b0;
    frame_boundary = 1'b0; cfg_ready = 1'b1;
    step();
    check("rst_led", int'(led_state), 1);
    check("rst_valid", int'(cfg_valid), 0);
    rst = 1'b0;
    step();

    // Single press, idle: valid two cycles after the edge
    press(4);
    check("t1_valid_early", int'(cfg_valid), 0);
    step();
    check("t1_valid", int'(cfg_valid), 1);
    check("t1_addr", int'(cfg_addr), 4);
    check("t1_data", int'(cfg_data), 1);
    step();
    check("t1_done_valid", int'(cfg_valid), 0);
    check("t1_done_led", int'(led_state), 1);

    // Wrap-around of tap 0
    for (int k = 1; k <= 33; k++) begin
      press(0);
      wait_accept(a, d);
      check("t2_addr", a, 0);
      check("t2_data", d, k % 32);
    end

    // Simultaneous requests: priority and idle gap
    btn_req[2] = 1'b1; btn_req[7] = 1'b1;
    step();
    btn_req = '0;
    wait_accept(a, d);
    check("t3_first_addr", a, 2);
    check("t3_first_data", d, 1);
    check("t3_gap", int'(cfg_valid), 0);
    wait_accept(a, d);
    check("t3_second_addr", a, 7);
    check("t3_second_data", d, 1);

    // Deferred write while sending
    send_enable_button = 1'b1;
    step();
    send_enable_button = 1'b0;
    check("t4_send_en", int'(send_en), 1);
    press(1);
    step();
    for (int k = 0; k < 4; k++) begin
      check("t4_hold_valid", int'(cfg_valid), 0);
      check("t4_hold_led", int'(led_state), 10);
      step();
    end
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
    check("t4_valid", int'(cfg_valid), 1);
    check("t4_addr", int'(cfg_addr), 1);
    step();

    // Stop, drain, frame boundary
    send_stop_button = 1'b1;
    step();
    send_stop_button = 1'b0;
    check("t6_drain_led", int'(led_state), 4);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_drain_en", int'(send_en), 1);
    end
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
    check("t6_idle_en", int'(send_en), 0);
    check("t6_idle_led", int'(led_state), 1);

    // Stalled write, then reset mid-stall
    cfg_ready = 1'b0;
    press(5);
    step();
    for (int k = 0; k < 5; k++) begin
      check("t5_stall_valid", int'(cfg_valid), 1);
      check("t5_stall_addr", int'(cfg_addr), 5);
      check("t5_stall_data", int'(cfg_data), 1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_valid", int'(cfg_valid), 0);
    check("t5_rst_led", int'(led_state), 1);
    cfg_ready = 1'b1;
    press(5);
    wait_accept(a, d);
    check("t5_after_rst_data", d, 1);
    cfg_ready = 1'b0;
    press(5);
    for (int k = 0; k < 6; k++) step();
    check("t5_stall2_data", int'(cfg_data), 2);
    cfg_ready = 1'b1;
    wait_accept(a, d);
    check("t5_commit_data", d, 2);
    press(5);
    wait_accept(a, d);
    check("t5_next_data", d, 3);

    // Edge during a stalled write is re-armed, not absorbed
    cfg_ready = 1'b0;
    press(6);
    step();
    press(6);
    cfg_ready = 1'b1;
    wait_accept(a, d);
    check("rearm_first", d, 1);
    wait_accept(a, d);
    check("rearm_addr", a, 6);
    check("rearm_second", d, 2);

    // Enable and stop together in IDLE resolve to stop
    send_enable_button = 1'b1; send_stop_button = 1'b1;
    step();
    send_enable_button = 1'b0; send_stop_button = 1'b0;
    check("t6_both_en", int'(send_en), 0);
    check("t6_both_led", int'(led_state), 1);

    // Random traffic against the model
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 9; b++)
        if ($urandom_range(0, 7) == 0) btn_req[b] = ~btn_req[b];
      if ($urandom_range(0, 15) == 0) send_enable_button = ~send_enable_button;
      if ($urandom_range(0, 23) == 0) send_stop_button = ~send_stop_button;
      frame_boundary = ($urandom_range(0, 9) == 0);
      cfg_ready      = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_delay_cfg_ctrl.md
Name: rgb_delay_cfg_ctrl

Overview:
Control-plane sequencer for the PAM4 RGB transmitter. It turns debounced delay-adjust buttons and send enable/stop buttons into a send-enable state machine and serialized tap-update writes for the per-colour delay lines (whole / rising / falling × R/G/B). It sits between the button debouncers and the delay-line/serializer datapath. While transmitting, it defers tap changes to frame boundaries so a symbol frame is never split across two delay settings.

Parameters:
TAP_W, 5, width of each delay tap value
MAX_TAP, 31, largest tap value; an increment past it wraps to 0 (MAX_TAP < 2**TAP_W)
N_REQ, 9, number of delay-adjust requesters (fixed by address map)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_req  in  N_REQ  debounced level buttons; idx 0..2 = r/g/b whole, 3..5 = r/g/b rising, 6..8 = r/g/b falling
send_enable_button  in  1  debounced level, start transmission
send_stop_button  in  1  debounced level, stop transmission
frame_boundary  in  1  one-cycle pulse from serializer at frame start
cfg_ready  in  1  delay-line block accepts write
cfg_valid  out  1  write request
cfg_addr  out  4  tap index (= btn_req index)
cfg_data  out  TAP_W  new tap value
send_en  out  1  serializer enable
led_state  out  4  status: [0] IDLE, [1] SENDING, [2] DRAIN, [3] cfg write in flight

Behaviour:
- Reset: one clock, synchronous, active-high. Every output is 0 in the cycle after rst is sampled high, except led_state = 4'b0001. All taps = 0, pending = 0, edge-detect history = 0. Reset mid-handshake drops cfg_valid with no commit.
- Edge detect: the register-delayed version of each input; a rising edge sets pending[i] in the next cycle. An edge while pending[i] is already set is absorbed (one increment only).
- Send FSM states: IDLE, SENDING, DRAIN.
  - IDLE → SENDING on an enable edge.
  - SENDING → DRAIN on a stop edge.
  - DRAIN → IDLE on frame_boundary.
  - An enable edge in SENDING or DRAIN is ignored.
  - A simultaneous enable and stop edge resolves to stop: IDLE stays IDLE; SENDING goes to DRAIN.
  - send_en = 1 in SENDING and DRAIN.
- Config FSM states: C_IDLE, C_WAIT, C_WRITE.
  - C_IDLE: if any pending bit is set, grant the lowest index (fixed priority). Go to C_WRITE if the send FSM is IDLE, otherwise go to C_WAIT.
  - C_WAIT: on frame_boundary go to C_WRITE next cycle. If the send FSM returns to IDLE, go straight to C_WRITE.
  - C_WRITE: cfg_valid = 1, cfg_addr = grant, cfg_data = (tap == MAX_TAP) ? 0 : tap + 1. All three are held stable until cfg_valid && cfg_ready.
  - On accept: the tap register takes cfg_data, pending[grant] clears, and the FSM returns to C_IDLE. No back-to-back writes: at least one C_IDLE cycle between transfers.
- Latency in IDLE with cfg_ready = 1: button edge at cycle n → pending set at n+1 → cfg_valid at n+2 → accepted at n+2 → tap updated at n+3.
- A new edge on an index being written, arriving during C_WRITE, sets pending again after the accept clears it (edge is captured, not lost).
- led_state[3] = (config FSM ≠ C_IDLE).

Decomposition:
- Package rgb_ctrl_pkg: send and config state encodings, requester index constants (R_WHOLE = 0 … B_FALL = 8), TAP_W default.
- Sub-module edge_rise (1-bit registered rising-edge detector), instantiated 11 times (9 delay buttons + enable + stop).
- Tap storage, arbiter and both FSMs stay in the top block.

Test Plan:
1. Reset; IDLE, cfg_ready = 1; pulse btn_req[4] → exactly one transfer, addr = 4, data = 1, valid at edge+2; led_state = 0001 after the write.
2. 32 separate presses of btn_req[0] → cfg_data sequence 1, 2, … 31, 0; final tap[0] = 0.
3. btn_req[2] and btn_req[7] rise in the same cycle → transfer addr 2 (data 1), at least one idle cycle, then addr 7 (data 1).
4. Enable edge → send_en = 1; press btn_req[1] → cfg_valid stays 0 and led_state = 1010 until frame_boundary; cfg_valid rises the next cycle with addr = 1.
5. cfg_ready = 0 for 5 cycles during C_WRITE → cfg_valid/addr/data stable; tap unchanged until the accept cycle. Assert rst mid-stall → cfg_valid = 0 next cycle, tap stays 0.
6. Stop edge in SENDING → DRAIN, send_en stays 1 until frame_boundary, then 0 next cycle. Enable and stop edges together in IDLE → remains IDLE, send_en = 0.
